// File: rtl/sort_pass_controller.sv
// Eight-element descending sorter: load 8 words, odd-even transposition sort with one shared
// compare-exchange unit, then drain. Optional early exit when a full even+odd pass makes no swap: SORT_EARLY_EXIT_EN.
module sort_pass_controller #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [2:0]        wr_idx_q, wr_idx_d;
  logic [2:0]        rd_idx_q, rd_idx_d;
  logic [2:0]        pass_q, pass_d;
  logic [1:0]        pair_q, pair_d;
  logic [DATA_W-1:0] buf_q [8];
  logic [DATA_W-1:0] buf_d [8];
`ifdef SORT_EARLY_EXIT_EN
  logic              flag_q, flag_d;
`endif

  logic [2:0] lo_idx, hi_idx;
  logic       last_pair, swap_now, sort_done;

  // Even passes start at index 0 (4 pairs), odd passes at index 1 (3 pairs).
  assign lo_idx    = {pair_q, 1'b0} + {2'b00, pass_q[0]};
  assign hi_idx    = lo_idx + 3'd1;
  assign last_pair = pass_q[0] ? (pair_q == 2'd2) : (pair_q == 2'd3);
  assign swap_now  = buf_q[hi_idx] > buf_q[lo_idx];

  assign out_data  = buf_q[rd_idx_q];
  assign busy      = (state_q != LOAD);

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    pass_d    = pass_q;
    pair_d    = pair_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    sort_done = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    flag_d    = flag_q;
`endif
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d[wr_idx_q] = in_data;
          wr_idx_d        = wr_idx_q + 3'd1;
          if (wr_idx_q == 3'd7) state_d = SORT;
        end
      end
      SORT: begin
        if (swap_now) begin
          buf_d[lo_idx] = buf_q[hi_idx];
          buf_d[hi_idx] = buf_q[lo_idx];
        end
`ifdef SORT_EARLY_EXIT_EN
        flag_d    = (!pass_q[0] && pair_q == 2'd0) ? swap_now : (flag_q | swap_now);
        sort_done = last_pair && ((pass_q == 3'd7) || (pass_q[0] && !(flag_q | swap_now)));
`else
        sort_done = last_pair && (pass_q == 3'd7);
`endif
        if (last_pair) begin
          pair_d = 2'd0;
          pass_d = pass_q + 3'd1;
        end else begin
          pair_d = pair_q + 2'd1;
        end
        if (sort_done) begin
          state_d  = DRAIN;
          pass_d   = 3'd0;
          pair_d   = 2'd0;
          rd_idx_d = 3'd0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_idx_q == 3'd7);
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 3'd1;
          if (rd_idx_q == 3'd7) begin
            state_d  = LOAD;
            wr_idx_d = 3'd0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_idx_q <= 3'd0;
      rd_idx_q <= 3'd0;
      pass_q   <= 3'd0;
      pair_q   <= 2'd0;
      buf_q    <= '{default: '0};
`ifdef SORT_EARLY_EXIT_EN
      flag_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      pass_q   <= pass_d;
      pair_q   <= pair_d;
      buf_q    <= buf_d;
`ifdef SORT_EARLY_EXIT_EN
      flag_q   <= flag_d;
`endif
    end
  end

endmodule

// File: tb/tb_sort_pass_controller.sv
// Randomized bench for sort_pass_controller against a descending-sort reference model.
module tb_sort_pass_controller;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_last, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frm [8];
  logic [7:0] exp_out [8];

  sort_pass_controller #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the sorted result is simply the frame in descending order.
  function automatic void model_sort();
    logic [7:0] t;
    exp_out = frm;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (exp_out[j] > exp_out[i]) begin
          t = exp_out[i]; exp_out[i] = exp_out[j]; exp_out[j] = t;
        end
  endfunction

  // Expected SORT duration: one cycle per pair, stopping after a swap-free even+odd pass when enabled.
  function automatic int exp_cycles();
    logic [7:0] a [8];
    logic [7:0] t;
    int cyc = 0;
    bit sw = 0;
    a = frm;
    for (int p = 0; p < 8; p++) begin
      if (p % 2 == 0) sw = 0;
      for (int k = p % 2; k + 1 < 8; k += 2) begin
        cyc++;
        if (a[k+1] > a[k]) begin
          t = a[k]; a[k] = a[k+1]; a[k+1] = t; sw = 1;
        end
      end
`ifdef SORT_EARLY_EXIT_EN
      if (p % 2 == 1 && !sw) break;
`endif
    end
    return cyc;
  endfunction

  // All tasks enter and leave at a falling edge.
  task automatic load_frame(input bit toggle);
    int idx = 0;
    int guard = 0;
    while (idx < 8 && guard < 64) begin
      check("load_in_ready", in_ready, 1);
      check("load_busy", busy, 0);
      in_valid = toggle ? 1'($urandom % 2) : 1'b1;
      in_data  = in_valid ? frm[idx] : 8'($urandom);
      if (in_valid) idx++;
      guard++;
      @(negedge clk);
    end
    check("load_count", idx, 8);
  endtask

  task automatic wait_sort(input bit hold);
    int cnt = 0;
    while (!out_valid && cnt < 100) begin
      check("sort_busy", busy, 1);
      check("sort_in_ready", in_ready, 0);
      in_valid  = hold ? 1'b1 : 1'($urandom % 2);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom % 2);
      cnt++;
      @(negedge clk);
    end
    check("sort_cycles", cnt, exp_cycles());
  endtask

  task automatic drain(input int nstall, input bit full_speed, input bit hold);
    int i = 0;
    int guard = 0;
    int stall = nstall;
    while (i < 8 && guard < 100) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, exp_out[i]);
      check("drain_last", out_last, (i == 7));
      check("drain_in_ready", in_ready, 0);
      in_valid = hold ? 1'b1 : 1'($urandom % 2);
      in_data  = 8'($urandom);
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = full_speed ? 1'b1 : 1'($urandom % 4 != 0);
      end
      if (out_ready) i++;
      guard++;
      @(negedge clk);
    end
    check("drain_count", i, 8);
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  task automatic run_frame(input bit toggle, input int nstall, input bit full_speed, input bit hold);
    model_sort();
    load_frame(toggle);
    wait_sort(hold);
    drain(nstall, full_speed, hold);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    frm = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd255, 8'd5, 8'd5};
    run_frame(0, 0, 1, 0);

    frm = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_frame(0, 0, 1, 0);

    for (int i = 0; i < 8; i++) frm[i] = 8'($urandom);
    run_frame(1, 0, 0, 0);

    for (int i = 0; i < 8; i++) frm[i] = 8'($urandom_range(10, 200));
    run_frame(0, 5, 1, 0);

    frm = '{default: 8'd42};
    run_frame(1, 0, 0, 0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) frm[i] = (f % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run_frame(f % 2, f, f % 3 == 0, 0);
    end

    // Asynchronous reset in the middle of SORT throws the frame away.
    for (int i = 0; i < 8; i++) frm[i] = 8'($urandom_range(1, 255));
    load_frame(0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_sort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frm = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_frame(0, 0, 1, 0);

    // Back-to-back frames with in_valid held high throughout.
    for (int i = 0; i < 8; i++) frm[i] = 8'($urandom);
    run_frame(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) frm[i] = 8'($urandom);
    run_frame(0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_pass_controller.md
SORT_PASS_CONTROLLER -- requirements
Module: sort_pass_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream element valid.
REQ-005 SHALL have port in_ready  output  1  block accepts element this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  unsigned element.
REQ-007 SHALL have port out_valid  output  1  sorted element valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts element.
REQ-009 SHALL have port out_data  output  DATA_W  sorted element.
REQ-010 SHALL have port out_last  output  1  marks eighth (smallest) output element.
REQ-011 SHALL have port busy  output  1  high in SORT or DRAIN.

Function
REQ-012 SHALL hold an 8-entry buffer buf[0..7] of DATA_W bits and one shared compare-exchange unit.
REQ-013 SHALL implement FSM states LOAD, SORT, DRAIN; reset state LOAD.
REQ-014 SHALL, in LOAD, drive in_ready=1 and write in_data to buf[wr_idx] on each in_valid&&in_ready, wr_idx incrementing 0..7.
REQ-015 SHALL transition LOAD->SORT on the edge accepting the eighth element; in_ready=0 outside LOAD.
REQ-016 SHALL, in SORT, perform exactly one compare-exchange per cycle: odd-even transposition, pass p=0..7; even passes pairs (0,1),(2,3),(4,5),(6,7); odd passes pairs (1,2),(3,4),(5,6); pairs in ascending index order.
REQ-017 SHALL place the larger of a pair at the lower index (descending order); equal values not swapped.
REQ-018 SHALL spend exactly 28 cycles in SORT (without early exit), then transition SORT->DRAIN.
REQ-019 SHALL, in DRAIN, drive out_valid=1, out_data=buf[rd_idx], rd_idx starting at 0, advancing on out_valid&&out_ready.
REQ-020 SHALL hold out_data stable while out_valid&&!out_ready.
REQ-021 SHALL assert out_last when rd_idx==7 in DRAIN; the transfer with out_last SHALL return the FSM to LOAD, counters cleared.
REQ-022 SHALL ignore in_valid outside LOAD and out_ready outside DRAIN.
REQ-023 SHALL produce a stable sort result for duplicated values (all-equal input passes through unchanged).

Reset
REQ-024 SHALL, on rst_n low, immediately set state=LOAD, wr_idx=rd_idx=pass=pair=0, swap flag=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-025 SHALL clear buf to 0 on reset; reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the frame.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro SORT_EARLY_EXIT_EN.
REQ-028 SHALL, with SORT_EARLY_EXIT_EN defined, track a swap flag cleared at start of each even pass and set on any swap; at the end of an odd pass with flag=0, SHALL transition to DRAIN next edge (minimum SORT duration 7 cycles).
REQ-029 SHALL, without SORT_EARLY_EXIT_EN, always run all 8 passes (28 cycles); swap flag logic absent.

Verification
REQ-030 SHALL pass: load 3,7,1,9,0,255,5,5 with out_ready=1 -> outputs 255,9,7,5,5,3,1,0, out_last on 0, 28 SORT cycles (macro off).
REQ-031 SHALL pass: load already-descending 8..1 with macro on -> SORT lasts 7 cycles, outputs 8..1.
REQ-032 SHALL pass: in_valid toggling 1/0 during LOAD -> only 8 accepted words stored; in_ready low from SORT entry until out_last transfer.
REQ-033 SHALL pass: out_ready held low 5 cycles in DRAIN -> out_valid=1, out_data constant (largest value) throughout.
REQ-034 SHALL pass: rst_n pulsed low mid-SORT -> outputs at reset values same cycle; next frame 1..8 sorts to 8..1.
REQ-035 SHALL pass: back-to-back frames, in_valid held high -> second frame accepted starting cycle after first out_last.
